paralelo_serial_tx: RTL and testbench
=====================================

Name: paralelo_serial_tx

Overview:
- Transmit serializer feeding the serial-to-parallel receiver.
- Takes 8-bit bytes from the clk_4f-rate datapath over a valid/ready handshake and drives one serial bit per clk_32f cycle, MSB first.
- Inserts the comma byte 0xBC after enable so the receiver can lock, and whenever no valid data is offered.
- Runs entirely on clk_32f; byte slots are framed by an internal 3-bit counter.

Parameters:
- COMMA, 8'hBC, idle/sync byte (1011_1100 on the line, MSB first).
- SYNC_COMMAS, 4, minimum commas sent after enable before data is accepted; the receiver locks on 4.
- CNT_W, 3, synchronisation comma counter width; must hold SYNC_COMMAS.

Ports:
- clk_32f  input  1  bit clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- tx_enable  input  1  transmitter enable, level.
- data_in  input  8  parallel byte.
- valid_in  input  1  data_in holds a byte to send.
- ready_out  output  1  a byte is accepted at this edge if valid_in is also high.
- data_out  output  1  serial bit, registered.
- active_out  output  1  high once sync commas are done and data may flow.

Behaviour:
- Reset (posedge with reset=1) forces:
  - state=IDLE, bit_cnt=7, sync_cnt=0, shift_reg=0
  - data_out=0, ready_out=0, active_out=0
  - reset mid-byte truncates the byte immediately.
- Slot framing:
  - bit_cnt increments 0..7 and wraps, except in IDLE, where it is held at 7.
  - A "load edge" is any posedge where bit_cnt==7 and the next state is not IDLE.
  - At a load edge: shift_reg<=next_byte, data_out<=next_byte[7], bit_cnt<=0.
  - At other edges: data_out<=shift_reg[6-bit_cnt].
  - Each byte therefore occupies exactly 8 consecutive cycles of data_out, MSB first.
- States:
  - IDLE: data_out=0, no commas, ready_out=0, active_out=0.
    - tx_enable=1 at a posedge -> SYNC; that same edge is a load edge with next_byte=COMMA.
  - SYNC: every slot carries COMMA.
    - sync_cnt increments at each load edge.
    - When the SYNC_COMMAS-th comma has finished (bit_cnt==7 and sync_cnt==SYNC_COMMAS) -> RUN.
    - active_out is set high on that edge.
  - RUN: ready_out = (bit_cnt==7), combinational from registers.
    - Load edge with valid_in=1: next_byte=data_in (byte accepted).
    - Load edge with valid_in=0: next_byte=COMMA.
    - data_in is sampled only at accept edges.
- tx_enable deassert (SYNC or RUN):
  - The current byte completes.
  - At bit_cnt==7 the block goes to IDLE: active_out=0, sync_cnt=0, no load.
  - Re-enable repeats the full SYNC sequence.
- Latency: a byte accepted at edge E drives its MSB on data_out after E and its LSB after E+7. Back-to-back accepts every 8 cycles give 100% line utilisation.
- A data byte equal to 0xBC is sent unchanged. Avoiding it is the upstream's responsibility.
- valid_in while ready_out=0 is ignored and must be held by the source.
- reset and tx_enable both high at the same edge: reset wins.

Decomposition:
- Shared package (phy_pkg):
  - COMMA_BC=8'hBC
  - SYNC_COMMAS_DEF=4
  - state encoding IDLE=2'd0, SYNC=2'd1, RUN=2'd2
- No sub-module. The FSM, bit counter, sync counter and shift register all live in one module. The receiver reuses the same package constants.

Test Plan:
- Reset 4 cycles, tx_enable=1, valid_in=0:
  - data_out shows 10111100 repeated, starting the cycle after the enable edge.
  - active_out rises exactly 32 cycles later.
  - ready_out pulses one cycle in every 8 from then on.
- After active, offer 0xA5 then 0x3C back-to-back with valid_in held:
  - Both are accepted on consecutive ready_out pulses.
  - Serial stream is 10100101 00111100, then BC idle.
- valid_in=1 asserted with bit_cnt=3:
  - Nothing accepted until the next ready_out.
  - The current comma completes intact.
- tx_enable dropped mid-byte 0x81:
  - 10000001 completes, then data_out=0, active_out=0.
  - Re-enable yields 4 commas before active_out rises again.
- reset pulsed at bit 4 of a data byte:
  - Next cycle data_out=0, ready_out=0, active_out=0.
  - Re-sync proceeds as in scenario 1.
- Loopback through the serial-to-parallel receiver, sending 0x00..0x0F:
  - Receiver valid_out asserts and data_out matches each byte in order.

Source files
------------

// File: rtl/phy_pkg.sv
// Constants and state encoding shared by the serial transmitter and receiver.
package phy_pkg;

    localparam logic [7:0] COMMA_BC        = 8'hBC;
    localparam int         SYNC_COMMAS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/paralelo_serial_tx.sv
// Byte-to-serial transmitter: MSB-first, one bit per clk_32f, comma-filled idle slots.
module paralelo_serial_tx
    import phy_pkg::*;
#(
    parameter logic [7:0] COMMA       = COMMA_BC,
    parameter int         SYNC_COMMAS = SYNC_COMMAS_DEF,
    parameter int         CNT_W       = 3
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       tx_enable,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       active_out
);

    localparam logic [CNT_W-1:0] SYNC_TARGET = CNT_W'(SYNC_COMMAS);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    tx_state_t        state;
    tx_state_t        next_state;
    logic [2:0]       bit_cnt;
    logic [CNT_W-1:0] sync_cnt;
    logic [7:0]       shift_reg;
    logic [7:0]       next_byte;
    logic             load;

    // Slot boundaries are the only points where the FSM may change state or pick a new byte.
    always_comb begin
        next_state = state;
        next_byte  = COMMA;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (tx_enable) begin
                    next_state = SYNC;
                    load       = 1'b1;
                end
            end
            SYNC: begin
                if (bit_cnt == 3'd7) begin
                    if (!tx_enable) begin
                        next_state = IDLE;
                    end else begin
                        load = 1'b1;
                        if (sync_cnt == SYNC_TARGET) begin
                            next_state = RUN;
                        end
                    end
                end
            end
            RUN: begin
                if (bit_cnt == 3'd7) begin
                    if (!tx_enable) begin
                        next_state = IDLE;
                    end else begin
                        load = 1'b1;
                        if (valid_in) begin
                            next_byte = data_in;
                        end
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign ready_out = (state == RUN) && (bit_cnt == 3'd7);

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= 3'd7;
            sync_cnt   <= '0;
            shift_reg  <= '0;
            data_out   <= 1'b0;
            active_out <= 1'b0;
        end else begin
            state <= next_state;

            if (load) begin
                shift_reg <= next_byte;
                data_out  <= next_byte[7];
                bit_cnt   <= 3'd0;
            end else if (next_state == IDLE) begin
                data_out <= 1'b0;
                bit_cnt  <= 3'd7;
            end else begin
                data_out <= shift_reg[3'd6 - bit_cnt];
                bit_cnt  <= bit_cnt + 3'd1;
            end

            // The enable edge counts as the first sync comma.
            if (next_state == IDLE) begin
                sync_cnt   <= '0;
                active_out <= 1'b0;
            end else if (load && next_state == SYNC) begin
                sync_cnt <= sync_cnt + CNT_ONE;
            end

            if (state == SYNC && next_state == RUN) begin
                active_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Directed bench for paralelo_serial_tx: sync commas, data slots, disable, reset, byte sweep.
module tb_paralelo_serial_tx;

    logic       clk_32f;
    logic       reset;
    logic       tx_enable;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       data_out;
    logic       active_out;

    int checks;
    int failures;

    paralelo_serial_tx dut (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .tx_enable  (tx_enable),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .active_out (active_out)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    task automatic tick();
        @(posedge clk_32f);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Called just after a load edge; checks bits lo..hi of the slot, one per cycle.
    task automatic checkBits(input string tag, input logic [7:0] exp_byte,
                             input int lo, input int hi, input logic rdy);
        logic [7:0] b;
        b = exp_byte;
        for (int i = lo; i <= hi; i++) begin
            checkOutput({tag, "_bit"}, {7'd0, data_out}, {7'd0, b[7-i]});
            checkOutput({tag, "_rdy"}, {7'd0, ready_out}, {7'd0, (rdy && i == 7)});
            tick();
        end
    endtask

    task automatic checkSlot(input string tag, input logic [7:0] exp_byte, input logic rdy);
        checkBits(tag, exp_byte, 0, 7, rdy);
    endtask

    // Enable edge followed by four sync commas; active must rise exactly 32 cycles later.
    task automatic syncSequence(input string tag);
        tick();
        for (int s = 0; s < 4; s++) begin
            checkOutput({tag, "_act_lo"}, {7'd0, active_out}, 8'd0);
            checkSlot({tag, "_comma"}, 8'hBC, 1'b0);
        end
        checkOutput({tag, "_act_hi"}, {7'd0, active_out}, 8'd1);
    endtask

    task automatic applyStimulus();
        // Reset state
        reset     = 1'b1;
        tx_enable = 1'b0;
        valid_in  = 1'b0;
        data_in   = 8'h00;
        repeat (4) tick();
        checkOutput("rst_data", {7'd0, data_out}, 8'd0);
        checkOutput("rst_rdy", {7'd0, ready_out}, 8'd0);
        checkOutput("rst_act", {7'd0, active_out}, 8'd0);

        // Scenario 1: enable, sync commas, first RUN comma
        reset     = 1'b0;
        tx_enable = 1'b1;
        syncSequence("sync1");
        checkSlot("run_comma", 8'hBC, 1'b1);

        // Scenario 2: A5 then 3C back-to-back, then idle comma
        valid_in = 1'b1;
        data_in  = 8'hA5;
        checkSlot("pre_a5", 8'hBC, 1'b1);
        data_in = 8'h3C;
        checkSlot("byte_a5", 8'hA5, 1'b1);
        valid_in = 1'b0;
        checkSlot("byte_3c", 8'h3C, 1'b1);
        checkSlot("idle_bc", 8'hBC, 1'b1);

        // Scenario 3: valid raised mid-comma is held off until the slot boundary
        checkBits("mid_valid_a", 8'hBC, 0, 2, 1'b1);
        valid_in = 1'b1;
        data_in  = 8'h81;
        checkBits("mid_valid_b", 8'hBC, 3, 7, 1'b1);
        valid_in = 1'b0;

        // Scenario 4: disable during 0x81; byte completes, then line goes quiet
        checkBits("dis_81_a", 8'h81, 0, 3, 1'b1);
        tx_enable = 1'b0;
        checkBits("dis_81_b", 8'h81, 4, 7, 1'b1);
        checkOutput("dis_data", {7'd0, data_out}, 8'd0);
        checkOutput("dis_act", {7'd0, active_out}, 8'd0);
        checkOutput("dis_rdy", {7'd0, ready_out}, 8'd0);
        tick();
        checkOutput("dis_data2", {7'd0, data_out}, 8'd0);
        tx_enable = 1'b1;
        syncSequence("sync2");
        checkSlot("run_comma2", 8'hBC, 1'b1);

        // Scenario 5: reset at bit 4 of 0x5A truncates immediately
        valid_in = 1'b1;
        data_in  = 8'h5A;
        checkSlot("pre_5a", 8'hBC, 1'b1);
        valid_in = 1'b0;
        checkBits("byte_5a", 8'h5A, 0, 3, 1'b1);
        reset = 1'b1;
        tick();
        checkOutput("mid_rst_data", {7'd0, data_out}, 8'd0);
        checkOutput("mid_rst_rdy", {7'd0, ready_out}, 8'd0);
        checkOutput("mid_rst_act", {7'd0, active_out}, 8'd0);
        reset = 1'b0;
        syncSequence("sync3");
        checkSlot("run_comma3", 8'hBC, 1'b1);

        // Scenario 6: back-to-back sweep 0x00..0x0F, then idle comma
        valid_in = 1'b1;
        for (int b = 0; b < 16; b++) begin
            data_in = 8'(b);
            checkSlot("sweep", (b == 0) ? 8'hBC : 8'(b - 1), 1'b1);
        end
        valid_in = 1'b0;
        checkSlot("sweep_last", 8'h0F, 1'b1);
        checkSlot("sweep_idle", 8'hBC, 1'b1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        applyStimulus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
